bridge_initiator: RTL and testbench
===================================

Name: bridge_initiator

Overview:
- Drives the 32-bit bridge bus from the initiating side, the opposite end to the core's bridge responder.
- Accepts single-word read/write commands on a valid/ready interface and issues them as one-cycle bridge strobes.
- Samples read data after a fixed latency and returns one response per command.
- Used as the bus driver in core-level benches and in loopback/self-test builds that exercise user register maps without the APF host.

Parameters:
- ADDR_WIDTH, 32, bridge address width
- DATA_WIDTH, 32, bridge data width
- RD_LATENCY, 2, cycles from the rd strobe cycle to the cycle rd_data is sampled (legal 1..15)
- GAP_CYCLES, 1, minimum idle cycles after each transaction before the next strobe (legal 0..15)

Ports:
- clk  input  1  bridge clock (clk_74a domain)
- reset  input  1  asynchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when valid&ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response available, held until accepted
- rsp_ready  input  1  response consumed when valid&ready
- rsp_write  output  1  echo of cmd_write
- rsp_rdata  output  DATA_WIDTH  sampled read data; 0 for writes
- bridge_addr  output  ADDR_WIDTH  bus address
- bridge_wr  output  1  one-cycle write strobe
- bridge_wr_data  output  DATA_WIDTH  write data
- bridge_rd  output  1  one-cycle read strobe
- bridge_rd_data  input  DATA_WIDTH  responder read data

Behaviour:
- Single clock, asynchronous active-high reset.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, bridge_addr=0, bridge_wr_data=0, bridge_wr=0, bridge_rd=0, state=IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/wdata/write into bridge_addr/bridge_wr_data and go to STROBE.
  - cmd_ready is registered-low from the next cycle.
- STROBE (1 cycle):
  - Asserts bridge_wr (write) or bridge_rd (read); never both.
  - Write -> RESP. Read -> WAIT with counter=RD_LATENCY-1.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0, sample bridge_rd_data into rsp_rdata and go to RESP.
  - Total: rd_data is sampled exactly RD_LATENCY cycles after the rd strobe cycle.
- RESP:
  - rsp_valid=1 with rsp_write/rsp_rdata stable.
  - On rsp_ready, go to GAP (GAP_CYCLES>0) or IDLE.
  - rsp_valid may stay high indefinitely; no timeout.
- GAP: counts GAP_CYCLES idle cycles with no strobes, then IDLE.
- Between transactions bridge_addr and bridge_wr_data hold their last values and are not re-driven to 0.
- Throughput, GAP_CYCLES=0, rsp_ready held 1:
  - Write: one transaction per 3 cycles (IDLE, STROBE, RESP).
  - Read: one per 3+RD_LATENCY cycles.
- Commands offered while busy stall (cmd_ready=0); cmd_* inputs may change freely while stalled.
- rsp_rdata for writes is forced to 0.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; any in-flight strobe is dropped and no response is produced.
  - After release, the first valid command is accepted on the first clk edge with reset low.
- At most one outstanding transaction: no pipelining, no reordering.

Decomposition:
- Shared package bridge_pkg:
  - state enum (IDLE, STROBE, WAIT, RESP, GAP)
  - typedef bridge_cmd_t {write, addr, wdata}
  - typedef bridge_rsp_t {write, rdata}
  - localparam for the 4-bit counter width
- One sub-module, bridge_delay_counter: a loadable down-counter with a zero flag, shared by the WAIT and GAP states.
- Everything else stays in bridge_initiator.

Test Plan:
- Write 0x0000_0010 <- 0xDEADBEEF, rsp_ready=1:
  - bridge_wr high for exactly 1 cycle with bridge_addr=0x10 and bridge_wr_data=0xDEADBEEF.
  - rsp_valid 1 cycle later with rsp_write=1, rsp_rdata=0.
- Read 0x0000_0020, responder model with RD_LATENCY=2 returns 0x1234_5678:
  - bridge_rd is a 1-cycle pulse.
  - rsp_rdata=0x12345678, rsp_write=0.
  - Sampled 2 cycles after the strobe; a wrong value presented on cycle 1 or 3 must not be captured.
- Back-to-back: 4 writes, then 4 reads of the same addresses against a register-file model:
  - Reads return the written data in order.
  - Strobes are separated by at least GAP_CYCLES (test GAP_CYCLES=0 and 3).
- Response backpressure: rsp_ready=0 for 10 cycles after a read:
  - rsp_valid and rsp_rdata stay stable.
  - cmd_ready=0 throughout; no new strobe.
  - The queued command issues after the accept.
- Reset asserted in WAIT:
  - All outputs return to reset values asynchronously.
  - No rsp_valid follows.
  - A post-reset write to 0x4 completes normally.
- Randomised valid/ready toggling over 1000 commands against the register-file model:
  - Response count equals command count.
  - bridge_wr and bridge_rd are never high together.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge initiator and its delay counter.
// The struct widths are those of the full 32-bit bridge bus.
package bridge_pkg;

  localparam int CNT_W      = 4;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP,
    GAP
  } bridge_state_t;

  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bridge_cmd_t;

  typedef struct packed {
    logic                  write;
    logic [BUS_DATA_W-1:0] rdata;
  } bridge_rsp_t;

  // A wait of N cycles loads N-1, because the zero cycle itself is the last one.
  function automatic logic [CNT_W-1:0] load_count(input int cycles);
    if (cycles > 0) begin
      return CNT_W'(cycles - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/bridge_delay_counter.sv
// Loadable down-counter with a zero flag.
// Shared by the read-latency wait and the post-transaction gap.
module bridge_delay_counter
  import bridge_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // The count holds at zero so the flag stays stable until the next load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bridge_initiator.sv
// Bridge bus initiator: turns single-word valid/ready commands into one-cycle
// bridge strobes and returns one response per command.
module bridge_initiator
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] bridge_addr,
  output logic                  bridge_wr,
  output logic [DATA_WIDTH-1:0] bridge_wr_data,
  output logic                  bridge_rd,
  input  logic [DATA_WIDTH-1:0] bridge_rd_data
);

  localparam logic [CNT_W-1:0] RD_LOAD  = load_count(RD_LATENCY);
  localparam logic [CNT_W-1:0] GAP_LOAD = load_count(GAP_CYCLES);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  bridge_state_t    state;
  bridge_state_t    state_next;
  logic             write_q;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_zero;

  bridge_delay_counter u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (cnt_load_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = STROBE;
        end
      end
      STROBE: begin
        state_next = write_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_zero) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready is gated by reset so a command is never taken while reset is held.
  always_comb begin
    cmd_ready      = (state == IDLE) && !reset;
    rsp_valid      = (state == RESP);
    bridge_wr      = (state == STROBE) && write_q;
    bridge_rd      = (state == STROBE) && !write_q;
    cnt_load       = (state == STROBE) || ((state == RESP) && rsp_ready);
    cnt_load_value = (state == STROBE) ? RD_LOAD : GAP_LOAD;
    cnt_en         = (state == WAIT) || (state == GAP);
  end

  assign accept = (state == IDLE) && cmd_valid;

  // Address and write data hold their last values between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bridge_addr    <= '0;
      bridge_wr_data <= '0;
      write_q        <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      if (accept) begin
        bridge_addr    <= cmd_addr;
        bridge_wr_data <= cmd_wdata;
        write_q        <= cmd_write;
      end
      if (state == STROBE) begin
        rsp_write <= write_q;
        rsp_rdata <= '0;
      end
      if ((state == WAIT) && cnt_zero) begin
        rsp_rdata <= bridge_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_bridge_initiator.sv
// Scoreboard bench for bridge_initiator: two instances (gap 0 and gap 3) share
// one register-file responder that presents read data only on the latency cycle.
module tb_bridge_initiator;
  import bridge_pkg::*;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        cmd_valid;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_ready;
  logic [31:0] bridge_rd_data;

  logic        cv0, cr0, rv0, rw0, bw0, br0;
  logic [31:0] rd0, ba0, bd0;
  logic        cv3, cr3, rv3, rw3, bw3, br3;
  logic [31:0] rd3, ba3, bd3;

  logic        cmd_ready, rsp_valid, rsp_write, bridge_wr, bridge_rd;
  logic [31:0] rsp_rdata, bridge_addr, bridge_wr_data;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cycle_cnt = 0;
  int          cmd_count = 0;
  int          rsp_count = 0;
  int          overlap_cnt = 0;
  int          spacing_err = 0;
  int          last_strobe = -1000;
  int          min_sep = 3;
  bridge_rsp_t sb_q[$];
  int          strobe_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] resp_mem [16];
  int          rd_age = 0;
  logic [31:0] rd_word = 32'd0;

  always #5 clk = ~clk;

  assign cv0 = cmd_valid & ~sel;
  assign cv3 = cmd_valid & sel;

  bridge_initiator #(.RD_LATENCY(RD_LAT), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cv0), .cmd_ready(cr0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_write(rw0), .rsp_rdata(rd0),
    .bridge_addr(ba0), .bridge_wr(bw0), .bridge_wr_data(bd0), .bridge_rd(br0),
    .bridge_rd_data(bridge_rd_data)
  );

  bridge_initiator #(.RD_LATENCY(RD_LAT), .GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cv3), .cmd_ready(cr3),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_write(rw3), .rsp_rdata(rd3),
    .bridge_addr(ba3), .bridge_wr(bw3), .bridge_wr_data(bd3), .bridge_rd(br3),
    .bridge_rd_data(bridge_rd_data)
  );

  assign cmd_ready      = sel ? cr3 : cr0;
  assign rsp_valid      = sel ? rv3 : rv0;
  assign rsp_write      = sel ? rw3 : rw0;
  assign rsp_rdata      = sel ? rd3 : rd0;
  assign bridge_addr    = sel ? ba3 : ba0;
  assign bridge_wr      = sel ? bw3 : bw0;
  assign bridge_wr_data = sel ? bd3 : bd0;
  assign bridge_rd      = sel ? br3 : br0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 8) return 32'h1234_5678;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Responder: correct data only RD_LAT cycles after the strobe cycle, junk otherwise.
  assign bridge_rd_data = (rd_age == RD_LAT) ? rd_word : (32'hBAD0_0000 | 32'(rd_age));

  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (bridge_wr) resp_mem[bridge_addr[5:2]] <= bridge_wr_data;
    if (bridge_rd) begin
      rd_age  <= 1;
      rd_word <= resp_mem[bridge_addr[5:2]];
    end else if (rd_age != 0 && rd_age < 15) begin
      rd_age <= rd_age + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard: everything sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if ((bw0 && br0) || (bw3 && br3)) overlap_cnt++;
      if (bridge_wr || bridge_rd) begin
        if (cycle_cnt - last_strobe < min_sep) spacing_err++;
        last_strobe = cycle_cnt;
        strobe_q.push_back(cycle_cnt);
      end
      if (cmd_valid && cmd_ready) begin
        bridge_rsp_t e;
        e.write = cmd_write;
        e.rdata = cmd_write ? 32'd0 : ref_mem[cmd_addr[5:2]];
        sb_q.push_back(e);
        if (cmd_write) ref_mem[cmd_addr[5:2]] = cmd_wdata;
        cmd_count++;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          bridge_rsp_t e;
          e = sb_q.pop_front();
          checkOutput("rsp_write", {63'd0, rsp_write}, {63'd0, e.write});
          checkOutput("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
        end
        rsp_count++;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bit accepted = 0;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        accepted = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDrain();
    bit done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && cmd_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    checkOutput({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    checkOutput({tag, "_strobes"}, {62'd0, bridge_wr, bridge_rd}, 64'd0);
    checkOutput({tag, "_addr"}, {32'd0, bridge_addr}, 64'd0);
    checkOutput({tag, "_wdata"}, {32'd0, bridge_wr_data}, 64'd0);
    checkOutput({tag, "_rsp"}, {31'd0, rsp_write, rsp_rdata}, 64'd0);
  endtask

  initial begin
    logic [31:0] words [4];
    logic [31:0] exp_rd;
    bit          seen;
    int          g, rsp_before, cmd_before;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i]  = init_word(i);
      resp_mem[i] = init_word(i);
    end
    sel = 1'b0; reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    #1;
    checkOutput("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Single write
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wr_strobe", {62'd0, bridge_wr, bridge_rd}, 64'd2);
    checkOutput("wr_addr", {32'd0, bridge_addr}, 64'h10);
    checkOutput("wr_data", {32'd0, bridge_wr_data}, 64'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("wr_pulse_end", {63'd0, bridge_wr}, 64'd0);
    checkOutput("wr_rsp", {30'd0, rsp_valid, rsp_write, rsp_rdata}, {30'd0, 2'b11, 32'd0});
    @(posedge clk);
    #1;
    waitDrain();

    // Single read: junk on cycles 1 and 3, good data only on cycle 2
    applyStimulus(1'b0, 32'h20, 32'd0);
    @(negedge clk);
    checkOutput("rd_strobe", {62'd0, bridge_wr, bridge_rd}, 64'd1);
    checkOutput("rd_addr", {32'd0, bridge_addr}, 64'h20);
    @(negedge clk);
    checkOutput("rd_pulse_end", {62'd0, bridge_rd, rsp_valid}, 64'd0);
    @(negedge clk);
    checkOutput("rd_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    checkOutput("rd_rsp", {30'd0, rsp_valid, rsp_write, rsp_rdata}, {30'd0, 2'b10, 32'h1234_5678});
    @(posedge clk);
    #1;
    waitDrain();

    // Back-to-back writes then reads, gap 0 then gap 3
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      g = s * 3;
      min_sep = 3 + g;
      last_strobe = -1000;
      strobe_q.delete();
      for (int i = 0; i < 4; i++) words[i] = $urandom;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), words[i]);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'(i * 4), 32'd0);
      waitDrain();
      if (strobe_q.size() == 8) begin
        for (int i = 1; i < 8; i++) begin
          checkOutput($sformatf("b2b_gap%0d_spacing%0d", g, i),
                      64'(strobe_q[i] - strobe_q[i-1]),
                      64'((i < 5) ? 3 + g : 3 + RD_LAT + g));
        end
      end else begin
        checkOutput("b2b_strobe_count", 64'(strobe_q.size()), 64'd8);
      end
      for (int i = 0; i < 4; i++) checkOutput("b2b_ref", {32'd0, ref_mem[i]}, {32'd0, words[i]});
    end

    // Response backpressure with a queued command
    sel = 1'b0;
    min_sep = 3;
    last_strobe = -1000;
    rsp_ready = 1'b0;
    exp_rd = ref_mem[2];
    applyStimulus(1'b0, 32'h8, 32'd0);
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFE_F00D; cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    checkOutput("bp_rsp_seen", {63'd0, seen}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, exp_rd});
      checkOutput("bp_stall", {61'd0, cmd_ready, bridge_wr, bridge_rd}, 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bridge_wr) begin seen = 1; break; end
    end
    cmd_valid = 1'b0;
    checkOutput("bp_queued_issue", {31'd0, seen, bridge_addr}, {31'd0, 1'b1, 32'h30});
    @(posedge clk);
    #1;
    waitDrain();

    // Reset in WAIT, then a write accepted on the first edge after release
    applyStimulus(1'b0, 32'h4, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    rsp_before = rsp_count;
    #1;
    checkResetValues("mid_reset");
    cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h600D_F00D; cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("post_rst_strobe", {31'd0, bridge_wr, bridge_addr}, {31'd0, 1'b1, 32'h4});
    waitDrain();
    checkOutput("post_rst_rsps", 64'(rsp_count - rsp_before), 64'd1);

    // Randomised valid/ready toggling, 500 commands per instance
    cmd_before = cmd_count;
    rsp_before = rsp_count;
    for (int s = 0; s < 2; s++) begin
      bit stim_done = 0;
      sel = s[0];
      min_sep = s ? 6 : 3;
      last_strobe = -1000;
      fork
        begin
          for (int n = 0; n < 500; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            applyStimulus(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
          end
          stim_done = 1;
        end
        begin
          while (!stim_done) begin
            @(posedge clk);
            #1;
            rsp_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      rsp_ready = 1'b1;
      waitDrain();
    end
    checkOutput("rand_cmds", 64'(cmd_count - cmd_before), 64'd1000);
    checkOutput("rand_rsps", 64'(rsp_count - rsp_before), 64'd1000);

    checkOutput("wr_rd_exclusive", 64'(overlap_cnt), 64'd0);
    checkOutput("strobe_spacing", 64'(spacing_err), 64'd0);
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
